// File: rtl/legv8_multicycle_sequencer.sv
// Multi-cycle LEGv8 control sequencer: steps FETCH/DECODE/EXEC/MEM/WB for the
// shared datapath and drives memory handshakes, PC/register strobes and ALU setup.
module legv8_multicycle_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        zero,
  output logic        imem_req,
  output logic        ir_load,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic        reg_write,
  output logic        alu_src,
  output logic        mem_to_reg,
  output logic [1:0]  alu_op,
  output logic        pc_inc,
  output logic        pc_branch,
  output logic [2:0]  state,
  output logic [1:0]  err,
  output logic [15:0] instr_count
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    CLS_ADD,
    CLS_SUB,
    CLS_LDUR,
    CLS_STUR,
    CLS_CBZ,
    CLS_B,
    CLS_ILL
  } cls_t;

  typedef struct packed {
    logic       imem_req;
    logic       dmem_read;
    logic       dmem_write;
    logic       reg_write;
    logic       alu_src;
    logic       mem_to_reg;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT);

  state_t      state_q;
  state_t      state_nxt;
  logic [10:0] opcode_q;
  logic [10:0] opcode_nxt;
  logic [7:0]  wait_cnt;
  logic [1:0]  err_q;
  logic [1:0]  err_nxt;
  logic [15:0] count_q;
  ctrl_t       ctrl_q;
  cls_t        cls_q;
  logic        retire;
  logic        unused_instr_bits;

  assign unused_instr_bits = ^instr[20:0];

  function automatic cls_t classify(input logic [10:0] op);
    cls_t c;
    if (op == 11'b10001011000)
      c = CLS_ADD;
    else if (op == 11'b11001011000)
      c = CLS_SUB;
    else if (op == 11'b11111000010)
      c = CLS_LDUR;
    else if (op == 11'b11111000000)
      c = CLS_STUR;
    else if (op[10:3] == 8'b10110100)
      c = CLS_CBZ;
    else if (op[10:5] == 6'b000101)
      c = CLS_B;
    else
      c = CLS_ILL;
    return c;
  endfunction

  // Level controls that depend only on state and instruction class.
  function automatic ctrl_t moore_ctrl(input state_t s, input cls_t c);
    ctrl_t o;
    o = '0;
    case (s)
      FETCH: o.imem_req = 1'b1;
      EXEC: begin
        case (c)
          CLS_SUB:            o.alu_op = 2'b01;
          CLS_LDUR, CLS_STUR: o.alu_src = 1'b1;
          CLS_CBZ:            o.alu_op = 2'b10;
          default:            o.alu_op = 2'b00;
        endcase
      end
      MEM: begin
        o.alu_src    = 1'b1;
        o.dmem_read  = (c == CLS_LDUR);
        o.dmem_write = (c == CLS_STUR);
      end
      WB: begin
        o.reg_write  = 1'b1;
        o.mem_to_reg = (c == CLS_LDUR);
      end
      default: o = '0;
    endcase
    return o;
  endfunction

  assign cls_q = classify(opcode_q);

  always_comb begin
    state_nxt  = state_q;
    opcode_nxt = opcode_q;
    err_nxt    = err_q;
    case (state_q)
      IDLE: state_nxt = FETCH;
      FETCH: begin
        if (imem_ready) begin
          state_nxt  = DECODE;
          opcode_nxt = instr[31:21];
        end else if (wait_cnt == WAIT_LIMIT) begin
          state_nxt = HALT;
          err_nxt   = 2'b10;
        end
      end
      DECODE: begin
        case (cls_q)
          CLS_ADD, CLS_SUB, CLS_LDUR, CLS_STUR, CLS_CBZ: state_nxt = EXEC;
          CLS_B: state_nxt = FETCH;
          default: begin
            state_nxt = HALT;
            err_nxt   = 2'b01;
          end
        endcase
      end
      EXEC: begin
        case (cls_q)
          CLS_ADD, CLS_SUB:   state_nxt = WB;
          CLS_LDUR, CLS_STUR: state_nxt = MEM;
          CLS_CBZ:            state_nxt = FETCH;
          default:            state_nxt = HALT;
        endcase
      end
      MEM: begin
        if (dmem_ready)
          state_nxt = (cls_q == CLS_LDUR) ? WB : FETCH;
        else if (wait_cnt == WAIT_LIMIT) begin
          state_nxt = HALT;
          err_nxt   = 2'b10;
        end
      end
      WB:      state_nxt = FETCH;
      default: state_nxt = HALT;
    endcase
  end

  // Level controls are registered from the next state so they change cleanly
  // on the clock; the wait counter only runs while a handshake is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      opcode_q <= '0;
      wait_cnt <= '0;
      err_q    <= 2'b00;
      count_q  <= '0;
      ctrl_q   <= '0;
    end else begin
      state_q  <= state_nxt;
      opcode_q <= opcode_nxt;
      err_q    <= err_nxt;
      ctrl_q   <= moore_ctrl(state_nxt, classify(opcode_nxt));
      if (retire)
        count_q <= count_q + 16'd1;
      if ((state_q == FETCH && !imem_ready) || (state_q == MEM && !dmem_ready))
        wait_cnt <= wait_cnt + 8'd1;
      else
        wait_cnt <= '0;
    end
  end

  // PC and IR pulses follow the handshake/zero inputs within the cycle.
  assign ir_load   = (state_q == FETCH) && imem_ready;
  assign pc_branch = ((state_q == DECODE) && (cls_q == CLS_B)) ||
                     ((state_q == EXEC) && (cls_q == CLS_CBZ) && zero);
  assign pc_inc    = ((state_q == EXEC) && (cls_q == CLS_CBZ) && !zero) ||
                     ((state_q == MEM) && (cls_q == CLS_STUR) && dmem_ready) ||
                     (state_q == WB);
  assign retire    = pc_inc | pc_branch;

  assign imem_req    = ctrl_q.imem_req;
  assign dmem_read   = ctrl_q.dmem_read;
  assign dmem_write  = ctrl_q.dmem_write;
  assign reg_write   = ctrl_q.reg_write;
  assign alu_src     = ctrl_q.alu_src;
  assign mem_to_reg  = ctrl_q.mem_to_reg;
  assign alu_op      = ctrl_q.alu_op;
  assign state       = state_q;
  assign err         = err_q;
  assign instr_count = count_q;

endmodule
